hashcore_seq: RTL and testbench

- Parametrised nonce sequencer and golden-nonce collector for a pipelined BLAKE hashing core.
- Generates the nonce stream with a per-core hardwired prefix and loads the start nonce when a serial work shift completes.
- Suppresses matches during pipeline warm-up and back-computes the golden nonce from the pipeline offset.
- Buffers golden nonces in a FIFO with a valid/ready drain port. Instantiated once per core beside the hashing core; the FIFO drains to the serial comms block.

---
 rtl/hashcore_pkg.sv | 27 ++
 rtl/gn_fifo.sv | 61 ++++++
 rtl/hashcore_seq.sv | 146 ++++++++++++++
 tb/tb_hashcore_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hashcore_pkg.sv
// Shared constants, types and helpers for the hashing-core nonce sequencer
// and its golden-nonce FIFO.
package hashcore_pkg;

    localparam int NONCE_W        = 32;
    localparam int DEF_WARMUP     = 64;
    localparam int DEF_GN_OFFSET  = 65;

    // Captured golden nonce waiting to be pushed into the FIFO.
    typedef struct packed {
        logic               vld;
        logic [NONCE_W-1:0] data;
    } gn_cap_t;

    // Ceiling log2, never below 1 so counters and pointers keep a real width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/gn_fifo.sv
// Small synchronous first-word fall-through FIFO with a valid/ready read port
// and a full flag; a pop in the same cycle frees space for a push.
module gn_fifo
    import hashcore_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CW     = ADDR_W + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_pop;
    logic              w_wr;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == CNT_FULL);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = o_valid & i_ready;
    assign w_wr    = i_push & (~o_full | w_pop);

    // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hashcore_seq.sv
// Nonce sequencer and golden-nonce collector placed beside one pipelined
// BLAKE core: drives the nonce stream and queues matches for the comms block.
module hashcore_seq
    import hashcore_pkg::*;
#(
    parameter int PREFIX_BITS = 3,
    parameter int WARMUP      = DEF_WARMUP,
    parameter int GN_OFFSET   = DEF_GN_OFFSET,
    parameter int GN_DEPTH    = 4,
    parameter int STOP_AT_END = 0,
    localparam int MSB_W      = (PREFIX_BITS == 0) ? 1 : PREFIX_BITS
) (
    input  logic               hash_clk,
    input  logic               reset_n,
    input  logic               shift,
    input  logic [MSB_W-1:0]   nonce_msb,
    input  logic [NONCE_W-1:0] initnonce,
    input  logic               gn_match,
    output logic [NONCE_W-1:0] nonce_out,
    output logic               gn_valid,
    output logic [NONCE_W-1:0] gn_data,
    input  logic               gn_ready,
    output logic               gn_overflow,
    output logic               done
);

    localparam int CNT_W  = NONCE_W - PREFIX_BITS;
    localparam int WARM_W = clog2(WARMUP + 1);
    localparam int DRN_W  = clog2(GN_OFFSET + 1);
    localparam logic [CNT_W-1:0]  CNT_END  = '1;
    localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(WARMUP);
    localparam logic [DRN_W-1:0]  DRN_MAX  = DRN_W'(GN_OFFSET);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    logic               r_shift_d;
    logic               r_armed;
    logic               r_done;
    logic               r_overflow;
    logic [WARM_W-1:0]  r_warm;
    logic [CNT_W-1:0]   r_cnt;
    logic [DRN_W-1:0]   r_drain;
    gn_cap_t            r_cap;
    logic               w_load;
    logic               w_hold;
    logic               w_match_ok;
    logic               w_pop;
    logic               w_drop;
    logic               w_fifo_full;
    logic [NONCE_W-1:0] w_nonce;
    logic [NONCE_W-1:0] w_golden;

    generate
        if (PREFIX_BITS == 0) begin : g_nopfx
            assign w_nonce = r_cnt;
        end else begin : g_pfx
            logic w_unused_init;
            assign w_nonce       = {nonce_msb, r_cnt};
            assign w_unused_init = ^initnonce[NONCE_W-1:CNT_W];
        end
    endgenerate

    // Reset asserts asynchronously but leaves only on a clock edge.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_load     = r_shift_d & ~shift;
    assign w_hold     = (STOP_AT_END != 0) && (r_cnt == CNT_END);
    // During drain the frozen count is extended by the drain counter.
    assign w_golden   = w_nonce + {{(NONCE_W-DRN_W){1'b0}}, r_drain} - NONCE_W'(GN_OFFSET);
    assign w_match_ok = r_armed & (r_warm == WARM_MAX) & gn_match & ~r_done
                        & ~(w_hold & (r_drain == DRN_MAX));
    assign w_pop      = gn_valid & gn_ready;
    assign w_drop     = r_cap.vld & w_fifo_full & ~w_pop;

    // Sequencer state: arming, warm-up, nonce count, drain, capture and overflow.
    always_ff @(posedge hash_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_shift_d  <= 1'b0;
            r_armed    <= 1'b0;
            r_warm     <= '0;
            r_cnt      <= '0;
            r_drain    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_cap      <= '0;
        end else begin
            r_shift_d <= shift;
            r_armed   <= r_armed | shift;

            if (!r_armed || r_shift_d) begin
                r_warm <= '0;
            end else if (r_warm != WARM_MAX) begin
                r_warm <= r_warm + WARM_W'(1);
            end

            if (w_load) begin
                r_cnt   <= initnonce[CNT_W-1:0];
                r_drain <= '0;
                r_done  <= 1'b0;
            end else if (w_hold) begin
                if (r_drain != DRN_MAX) begin
                    r_drain <= r_drain + DRN_W'(1);
                end
                r_done <= r_done | (r_drain == (DRN_MAX - DRN_W'(1)));
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_drain <= '0;
            end

            r_cap.vld  <= w_match_ok;
            r_cap.data <= w_golden;

            if (w_load) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    gn_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (GN_DEPTH)
    ) u_gn_fifo (
        .i_clk       (hash_clk),
        .i_rst_n     (w_rst_n),
        .i_push      (r_cap.vld),
        .i_push_data (r_cap.data),
        .i_ready     (gn_ready),
        .o_valid     (gn_valid),
        .o_data      (gn_data),
        .o_full      (w_fifo_full)
    );

    assign nonce_out   = w_nonce;
    assign gn_overflow = r_overflow;
    assign done        = r_done;

endmodule

// File: tb/tb_hashcore_seq.sv
// Directed bench for hashcore_seq: a wrapping 3-bit-prefix instance and a
// stop-at-end 8-bit-prefix instance sharing one clock and reset.
module tb_hashcore_seq;

    logic        hash_clk = 1'b0;
    logic        reset_n;
    logic        shift, gn_match, gn_ready;
    logic [2:0]  nonce_msb = 3'b101;
    logic [31:0] initnonce;
    logic [31:0] nonce_out, gn_data;
    logic        gn_valid, gn_overflow, done;

    logic        shift1, gn_match1, gn_ready1;
    logic [7:0]  nonce_msb1 = 8'hC3;
    logic [31:0] initnonce1;
    logic [31:0] nonce_out1, gn_data1;
    logic        gn_valid1, gn_overflow1, done1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] nonce;
        logic [31:0] gold;
    } vec_t;
    vec_t vec_a [5];
    vec_t vec_b [5];

    always #5 hash_clk = ~hash_clk;

    hashcore_seq #(.PREFIX_BITS(3), .WARMUP(64), .GN_OFFSET(65), .GN_DEPTH(4), .STOP_AT_END(0)) u_dut (
        .hash_clk(hash_clk), .reset_n(reset_n), .shift(shift), .nonce_msb(nonce_msb),
        .initnonce(initnonce), .gn_match(gn_match), .nonce_out(nonce_out),
        .gn_valid(gn_valid), .gn_data(gn_data), .gn_ready(gn_ready),
        .gn_overflow(gn_overflow), .done(done)
    );

    hashcore_seq #(.PREFIX_BITS(8), .WARMUP(8), .GN_OFFSET(65), .GN_DEPTH(4), .STOP_AT_END(1)) u_dut1 (
        .hash_clk(hash_clk), .reset_n(reset_n), .shift(shift1), .nonce_msb(nonce_msb1),
        .initnonce(initnonce1), .gn_match(gn_match1), .nonce_out(nonce_out1),
        .gn_valid(gn_valid1), .gn_data(gn_data1), .gn_ready(gn_ready1),
        .gn_overflow(gn_overflow1), .done(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_nonce(input logic [31:0] target);
        int n;
        n = 0;
        while (nonce_out !== target && n < 3000) begin
            @(negedge hash_clk);
            n++;
        end
        check("wait_nonce", nonce_out, target);
    endtask

    task automatic load0(input logic [31:0] val);
        initnonce = val;
        shift = 1'b1;
        repeat (3) @(negedge hash_clk);
        shift = 1'b0;
        @(negedge hash_clk);
    endtask

    task automatic pulse0();
        gn_match = 1'b1;
        @(negedge hash_clk);
        gn_match = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        vec_a[0] = '{32'hA000_1100, 32'hA000_10BF};
        vec_a[1] = '{32'hA000_1110, 32'hA000_10CF};
        vec_a[2] = '{32'hA000_1120, 32'hA000_10DF};
        vec_a[3] = '{32'hA000_1130, 32'hA000_10EF};
        vec_a[4] = '{32'hA000_1140, 32'hA000_10FF};
        vec_b[0] = '{32'hA000_2100, 32'hA000_20BF};
        vec_b[1] = '{32'hA000_2110, 32'hA000_20CF};
        vec_b[2] = '{32'hA000_2120, 32'hA000_20DF};
        vec_b[3] = '{32'hA000_2130, 32'hA000_20EF};
        vec_b[4] = '{32'hA000_2140, 32'hA000_20FF};

        reset_n = 1'b0; shift = 1'b0; gn_match = 1'b0; gn_ready = 1'b0; initnonce = 32'h0;
        shift1 = 1'b0; gn_match1 = 1'b0; gn_ready1 = 1'b0; initnonce1 = 32'h0;
        repeat (3) @(negedge hash_clk);
        check("rst nonce_out", nonce_out, 32'hA000_0000);
        check("rst gn_valid", {31'h0, gn_valid}, 32'h0);
        check("rst gn_data", gn_data, 32'h0);
        check("rst overflow", {31'h0, gn_overflow}, 32'h0);
        check("rst done", {31'h0, done}, 32'h0);
        check("rst nonce_out1", nonce_out1, 32'hC300_0000);
        reset_n = 1'b1;
        repeat (4) @(negedge hash_clk);

        // Load and free-running increment.
        load0(32'h0000_1000);
        check("load nonce", nonce_out, 32'hA000_1000);
        @(negedge hash_clk);
        check("inc1 nonce", nonce_out, 32'hA000_1001);
        @(negedge hash_clk);
        check("inc2 nonce", nonce_out, 32'hA000_1002);

        // Match inside warm-up is ignored.
        wait_nonce(32'hA000_100A);
        pulse0();
        repeat (3) @(negedge hash_clk);
        check("warmup ignored", {31'h0, gn_valid}, 32'h0);

        // Five matches into a depth-4 FIFO with no consumer.
        for (int i = 0; i < 5; i++) begin
            wait_nonce(vec_a[i].nonce);
            pulse0();
            if (i == 0) begin
                check("valid not early", {31'h0, gn_valid}, 32'h0);
                @(negedge hash_clk);
                check("first valid", {31'h0, gn_valid}, 32'h1);
                check("first data", gn_data, vec_a[0].gold);
            end
        end
        repeat (3) @(negedge hash_clk);
        check("overflow set", {31'h0, gn_overflow}, 32'h1);
        gn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain valid", {31'h0, gn_valid}, 32'h1);
            check("drain data", gn_data, vec_a[i].gold);
            @(negedge hash_clk);
        end
        gn_ready = 1'b0;
        check("drained empty", {31'h0, gn_valid}, 32'h0);
        check("overflow sticky", {31'h0, gn_overflow}, 32'h1);

        // Reload clears overflow; full FIFO with simultaneous push and pop.
        load0(32'h0000_2000);
        check("load2 nonce", nonce_out, 32'hA000_2000);
        check("load clears ovf", {31'h0, gn_overflow}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            wait_nonce(vec_b[i].nonce);
            pulse0();
        end
        repeat (3) @(negedge hash_clk);
        check("full no ovf", {31'h0, gn_overflow}, 32'h0);
        check("full head", gn_data, vec_b[0].gold);
        wait_nonce(vec_b[4].nonce);
        pulse0();
        gn_ready = 1'b1;
        @(negedge hash_clk);
        gn_ready = 1'b0;
        check("push+pop no ovf", {31'h0, gn_overflow}, 32'h0);
        gn_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("pp valid", {31'h0, gn_valid}, 32'h1);
            check("pp data", gn_data, vec_b[i].gold);
            @(negedge hash_clk);
        end
        gn_ready = 1'b0;
        check("pp empty", {31'h0, gn_valid}, 32'h0);

        // Asynchronous reset with two entries queued.
        wait_nonce(32'hA000_2200);
        pulse0();
        wait_nonce(32'hA000_2210);
        pulse0();
        repeat (3) @(negedge hash_clk);
        check("pre-rst valid", {31'h0, gn_valid}, 32'h1);
        check("pre-rst data", gn_data, 32'hA000_21BF);
        #2 reset_n = 1'b0;
        #1;
        check("async rst valid", {31'h0, gn_valid}, 32'h0);
        check("async rst data", gn_data, 32'h0);
        check("async rst nonce", nonce_out, 32'hA000_0000);
        check("async rst ovf", {31'h0, gn_overflow}, 32'h0);
        @(negedge hash_clk);
        reset_n = 1'b1;
        repeat (4) @(negedge hash_clk);
        gn_match = 1'b1;
        repeat (5) @(negedge hash_clk);
        gn_match = 1'b0;
        repeat (3) @(negedge hash_clk);
        check("unarmed no push", {31'h0, gn_valid}, 32'h0);

        // Stop-at-end instance: freeze, drain window, done.
        initnonce1 = 32'h00FF_FFF0;
        shift1 = 1'b1;
        repeat (3) @(negedge hash_clk);
        shift1 = 1'b0;
        @(negedge hash_clk);
        check("s load nonce", nonce_out1, 32'hC3FF_FFF0);
        for (int n = 0; n < 100 && nonce_out1 !== 32'hC3FF_FFFF; n++) begin
            @(negedge hash_clk);
        end
        check("s reach end", nonce_out1, 32'hC3FF_FFFF);
        for (int k = 0; k < 70; k++) begin
            if (k == 10) begin
                gn_match1 = 1'b1;
                check("s done low mid", {31'h0, done1}, 32'h0);
            end
            if (k == 11) gn_match1 = 1'b0;
            if (k == 12) begin
                check("s drain valid", {31'h0, gn_valid1}, 32'h1);
                check("s drain golden", gn_data1, 32'hC3FF_FFC8);
                gn_ready1 = 1'b1;
            end
            if (k == 13) begin
                gn_ready1 = 1'b0;
                check("s popped", {31'h0, gn_valid1}, 32'h0);
            end
            if (k == 64) begin
                check("s done at 64", {31'h0, done1}, 32'h0);
                check("s frozen", nonce_out1, 32'hC3FF_FFFF);
            end
            if (k == 65) check("s done at 65", {31'h0, done1}, 32'h1);
            if (k == 66) gn_match1 = 1'b1;
            if (k == 67) gn_match1 = 1'b0;
            if (k == 69) begin
                check("s post-done ignored", {31'h0, gn_valid1}, 32'h0);
                check("s done held", {31'h0, done1}, 32'h1);
            end
            @(negedge hash_clk);
        end
        initnonce1 = 32'h00FF_FF00;
        shift1 = 1'b1;
        repeat (3) @(negedge hash_clk);
        shift1 = 1'b0;
        @(negedge hash_clk);
        check("s reload done", {31'h0, done1}, 32'h0);
        check("s reload nonce", nonce_out1, 32'hC3FF_FF00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
